// File: rtl/sb_handshake_retry.sv
// rtl/sb_handshake_retry.sv - two-way sideband REQ/RESP handshake with timeout and bounded retry
// Sends REQ, answers the partner REQ with RESP, completes once both directions are done.
module sb_handshake_retry #(
   parameter int SB_MSG_WIDTH   = 4,
   parameter int REQ_MSG        = 15,
   parameter int RESP_MSG       = 14,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MAX_RETRY      = 2,
   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1,
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_en,
   input  logic                    i_msg_valid,
   input  logic [SB_MSG_WIDTH-1:0] i_Rx_SbMessage,
   input  logic                    i_falling_edge_busy,
   output logic [SB_MSG_WIDTH-1:0] o_TX_SbMessage,
   output logic                    o_valid,
   output logic                    o_done,
   output logic                    o_timeout_err,
   output logic [RW-1:0]           o_retry_cnt
);

   localparam logic [SB_MSG_WIDTH-1:0] REQ_CODE   = SB_MSG_WIDTH'(REQ_MSG);
   localparam logic [SB_MSG_WIDTH-1:0] RESP_CODE  = SB_MSG_WIDTH'(RESP_MSG);
   localparam logic [TW-1:0]           TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0]           RETRY_MAX  = RW'(MAX_RETRY);

   typedef enum logic [2:0] {
      IDLE, SEND_REQ, WAIT, SEND_RESP, DONE, ERROR
   } state_t;

   state_t          state_q, state_d;
   logic [TW-1:0]   timer_q;
   logic [RW-1:0]   retry_q;
   logic            req_rcvd, resp_rcvd, resp_sent;
   logic            retry_fire, resp_done, counting;

   assign counting = (state_q == SEND_REQ) || (state_q == WAIT) || (state_q == SEND_RESP);

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      retry_fire = 1'b0;
      resp_done  = 1'b0;
      if (!i_en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:     state_d = SEND_REQ;
            SEND_REQ: if (i_falling_edge_busy) state_d = WAIT;
            WAIT: begin
               if (req_rcvd && !resp_sent)      state_d = SEND_RESP;
               else if (resp_rcvd && resp_sent) state_d = DONE;
               else if (timer_q == TIMER_LAST) begin
                  if (retry_q < RETRY_MAX) begin
                     retry_fire = 1'b1;
                     state_d    = SEND_REQ;
                  end else begin
                     state_d = ERROR;
                  end
               end
            end
            SEND_RESP: begin
               if (i_falling_edge_busy) begin
                  resp_done = 1'b1;
                  state_d   = WAIT;
               end
            end
            DONE:    state_d = DONE;
            ERROR:   state_d = ERROR;
            default: state_d = IDLE;
         endcase
      end
   end

   // Saturates so a stalled SEND_REQ/SEND_RESP cannot wrap; expiry is acted on in WAIT.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_en || state_q == IDLE || retry_fire)
         timer_q <= '0;
      else if (counting && timer_q != TIMER_LAST)
         timer_q <= timer_q + TW'(1);
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_en || state_q == IDLE)
         retry_q <= '0;
      else if (retry_fire)
         retry_q <= retry_q + RW'(1);
   end

   // Flags latch in every enabled state so early partner traffic is kept across retries.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || !i_en) begin
         req_rcvd  <= 1'b0;
         resp_rcvd <= 1'b0;
         resp_sent <= 1'b0;
      end else begin
         if (i_msg_valid && i_Rx_SbMessage == REQ_CODE)  req_rcvd  <= 1'b1;
         if (i_msg_valid && i_Rx_SbMessage == RESP_CODE) resp_rcvd <= 1'b1;
         if (resp_done)                                  resp_sent <= 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_TX_SbMessage <= '0;
         o_valid        <= 1'b0;
         o_done         <= 1'b0;
         o_timeout_err  <= 1'b0;
      end else begin
         o_TX_SbMessage <= (state_d == SEND_REQ)  ? REQ_CODE  :
                           (state_d == SEND_RESP) ? RESP_CODE : '0;
         o_valid        <= (state_d == SEND_REQ) || (state_d == SEND_RESP);
         o_done         <= (state_d == DONE);
         o_timeout_err  <= (state_d == ERROR);
      end
   end

   assign o_retry_cnt = retry_q;

endmodule

// File: tb/tb_sb_handshake_retry.sv
// tb/tb_sb_handshake_retry.sv - directed and randomized checks of sb_handshake_retry against a behavioural model
module tb_sb_handshake_retry;

   localparam int T_OUT = 16;
   localparam int M_RET = 2;

   logic       i_clk = 1'b0;
   logic       i_rst_n, i_en, i_msg_valid, i_falling_edge_busy;
   logic [3:0] i_Rx_SbMessage;
   logic [3:0] o_TX_SbMessage;
   logic       o_valid, o_done, o_timeout_err;
   logic [1:0] o_retry_cnt;

   int checks = 0;
   int failures = 0;

   sb_handshake_retry dut (
      .i_clk               (i_clk),
      .i_rst_n             (i_rst_n),
      .i_en                (i_en),
      .i_msg_valid         (i_msg_valid),
      .i_Rx_SbMessage      (i_Rx_SbMessage),
      .i_falling_edge_busy (i_falling_edge_busy),
      .o_TX_SbMessage      (o_TX_SbMessage),
      .o_valid             (o_valid),
      .o_done              (o_done),
      .o_timeout_err       (o_timeout_err),
      .o_retry_cnt         (o_retry_cnt)
   );

   always #5 i_clk = ~i_clk;

   // Phases of the exchange as the partner sees it.
   localparam int P_OFF = 0, P_ASK = 1, P_LISTEN = 2, P_ANSWER = 3, P_OK = 4, P_FAIL = 5;
   int m_phase = P_OFF;
   int m_age = 0;
   int m_retry = 0;
   bit m_req = 0, m_resp = 0, m_sent = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_step(input bit rst_n, input bit en, input bit v, input int code, input bit busy);
      int nxt;
      if (!rst_n || !en) begin
         m_phase = P_OFF; m_age = 0; m_retry = 0;
         m_req = 0; m_resp = 0; m_sent = 0;
         return;
      end
      nxt = m_phase;
      case (m_phase)
         P_OFF:    begin nxt = P_ASK; m_retry = 0; end
         P_ASK:    if (busy) nxt = P_LISTEN;
         P_LISTEN: begin
            if (m_req && !m_sent)      nxt = P_ANSWER;
            else if (m_resp && m_sent) nxt = P_OK;
            else if (m_age >= T_OUT - 1) begin
               if (m_retry < M_RET) begin m_retry++; nxt = P_ASK; end
               else nxt = P_FAIL;
            end
         end
         P_ANSWER: if (busy) begin nxt = P_LISTEN; m_sent = 1; end
         default: ;
      endcase
      // Attempt age: cycles spent in the current attempt; restarts at each REQ (re)send.
      if (m_phase == P_OFF || (m_phase == P_LISTEN && nxt == P_ASK)) m_age = 0;
      else if (m_phase inside {P_ASK, P_LISTEN, P_ANSWER}) m_age++;
      if (v && code == 15) m_req = 1;
      if (v && code == 14) m_resp = 1;
      m_phase = nxt;
   endtask

   task automatic compare_all(input string tag);
      int exp_tx;
      exp_tx = (m_phase == P_ASK) ? 15 : (m_phase == P_ANSWER) ? 14 : 0;
      check({tag, ".tx"},    o_TX_SbMessage, exp_tx);
      check({tag, ".valid"}, o_valid, (m_phase == P_ASK || m_phase == P_ANSWER));
      check({tag, ".done"},  o_done, m_phase == P_OK);
      check({tag, ".err"},   o_timeout_err, m_phase == P_FAIL);
      check({tag, ".retry"}, o_retry_cnt, m_retry);
   endtask

   task automatic cyc(input string tag, input bit en, input bit v, input int code,
                      input bit busy, input bit rst_n = 1'b1);
      i_rst_n = rst_n; i_en = en; i_msg_valid = v;
      i_Rx_SbMessage = code[3:0]; i_falling_edge_busy = busy;
      @(posedge i_clk);
      model_step(rst_n, en, v, code, busy);
      #1;
      compare_all(tag);
   endtask

   initial begin
      i_rst_n = 0; i_en = 0; i_msg_valid = 0; i_Rx_SbMessage = 0; i_falling_edge_busy = 0;
      cyc("reset", 0, 0, 0, 0, 0);
      check("reset_valid", o_valid, 0);
      check("reset_tx", o_TX_SbMessage, 0);

      // Normal exchange
      cyc("norm_en", 1, 0, 0, 0);
      check("norm_req_tx", o_TX_SbMessage, 15);
      cyc("norm", 1, 0, 0, 0);
      cyc("norm", 1, 0, 0, 0);
      cyc("norm_busy", 1, 0, 0, 1);
      check("norm_wait_valid", o_valid, 0);
      cyc("norm_req", 1, 1, 15, 0);
      cyc("norm_resp", 1, 1, 14, 0);
      check("norm_resp_tx", o_TX_SbMessage, 14);
      cyc("norm_busy2", 1, 0, 0, 1);
      cyc("norm_end", 1, 0, 0, 0);
      check("norm_done", o_done, 1);
      check("norm_retry", o_retry_cnt, 0);
      cyc("norm_off", 0, 0, 0, 0);
      check("norm_off_done", o_done, 0);

      // Early partner REQ on the enable cycle
      cyc("early_en", 1, 1, 15, 0);
      cyc("early_busy", 1, 0, 0, 1);
      cyc("early_w", 1, 0, 0, 0);
      check("early_resp_tx", o_TX_SbMessage, 14);
      cyc("early_busy2", 1, 1, 14, 1);
      cyc("early_end", 1, 0, 0, 0);
      check("early_done", o_done, 1);
      cyc("early_off", 0, 0, 0, 0);

      // Timeout with retries, unrelated codes ignored along the way
      cyc("to_en", 1, 0, 0, 0);
      for (int i = 1; i <= 48; i++) begin
         cyc("to", 1, (i == 5 || i == 6), (i == 5) ? 7 : 0, (i == 1 || i == 17 || i == 33));
         if (i == 6) begin
            i_msg_valid = 0; i_Rx_SbMessage = 14;
            cyc("to_unq", 1, 0, 14, 0);
            i++;
         end
         if (i == 16) begin check("to_r1_valid", o_valid, 1); check("to_r1_cnt", o_retry_cnt, 1); end
         if (i == 32) begin check("to_r2_valid", o_valid, 1); check("to_r2_cnt", o_retry_cnt, 2); end
         if (i == 48) begin check("to_err", o_timeout_err, 1); check("to_err_valid", o_valid, 0); end
      end
      cyc("to_off", 0, 0, 0, 0);

      // Recovery after the first retry
      cyc("rec_en", 1, 0, 0, 0);
      for (int i = 1; i <= 24; i++) begin
         cyc("rec", 1, (i == 18 || i == 19), (i == 18) ? 14 : 15, (i == 1 || i == 17 || i == 21));
         check("rec_no_err", o_timeout_err, 0);
      end
      check("rec_done", o_done, 1);
      check("rec_retry", o_retry_cnt, 1);
      cyc("rec_off", 0, 0, 0, 0);

      // Abort during SEND_RESP, then reset in WAIT
      cyc("ab_en", 1, 1, 15, 0);
      cyc("ab_busy", 1, 0, 0, 1);
      cyc("ab_w", 1, 0, 0, 0);
      cyc("ab_drop", 0, 0, 0, 0);
      check("ab_valid", o_valid, 0);
      cyc("ab_re", 1, 0, 0, 0);
      cyc("ab_busy2", 1, 0, 0, 1);
      cyc("ab_rst", 1, 0, 0, 0, 0);
      check("ab_rst_tx", o_TX_SbMessage, 0);
      cyc("ab_re2", 1, 0, 0, 0);
      check("ab_re2_retry", o_retry_cnt, 0);
      check("ab_re2_tx", o_TX_SbMessage, 15);

      // Randomized traffic
      for (int n = 0; n < 4000; n++) begin
         int r, code;
         r = $urandom_range(0, 3);
         code = (r == 0) ? 15 : (r == 1) ? 14 : int'($urandom_range(0, 15));
         cyc("rnd", $urandom_range(0, 149) != 0, $urandom_range(0, 5) == 0, code,
             $urandom_range(0, 4) == 0, $urandom_range(0, 499) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
